// File: rtl/gate_sweep_checker_pkg.sv
// rtl/gate_sweep_checker_pkg.sv - shared state encoding, gate bit indices and expected-value function
package gate_chk_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DRIVE  = ST_DRIVE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_e;

    localparam int IDX_NOTA = 7;
    localparam int IDX_NOTB = 6;
    localparam int IDX_AND  = 5;
    localparam int IDX_NAND = 4;
    localparam int IDX_OR   = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    function automatic logic [7:0] exp_gates(input logic a, input logic b);
        logic [7:0] e;
        e           = '0;
        e[IDX_NOTA] = ~a;
        e[IDX_NOTB] = ~b;
        e[IDX_AND]  = a & b;
        e[IDX_NAND] = ~(a & b);
        e[IDX_OR]   = a | b;
        e[IDX_NOR]  = ~(a | b);
        e[IDX_XOR]  = a ^ b;
        e[IDX_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - stimulus/response bus between the checker and the gate model
interface gate_sweep_checker_if;
    logic       a_out;
    logic       b_out;
    logic [7:0] y_in;

    modport master (output a_out, output b_out, input y_in);
    modport slave  (input a_out, input b_out, output y_in);
endinterface

// File: rtl/gate_sweep_checker_expect.sv
// rtl/gate_sweep_checker_expect.sv - combinational expected outputs of the two-input all-gates model
module gate_expect
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [7:0] exp_o
);
    assign exp_o = exp_gates(a_i, b_i);
endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps {a,b} over the gate model, samples after a settle window, scores mismatches
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    gate_sweep_checker_if.master gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_fail_valid,
    output logic [1:0]           first_fail_vec,
    output logic [7:0]           first_fail_mask
);
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_e             state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [PASS_W-1:0]  pass_idx_q, pass_idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               ffv_q, ffv_d;
    logic [1:0]         ffvec_q, ffvec_d;
    logic [7:0]         ffmask_q, ffmask_d;
    logic [1:0]         ab_q, ab_d;

    logic [7:0]         exp_w;
    logic [7:0]         diff_w;
    logic               mismatch_w;

    gate_expect u_expect (
        .a_i   (vec_q[1]),
        .b_i   (vec_q[0]),
        .exp_o (exp_w)
    );

    // Case inequality so that an undriven or floating model output is scored as a failure.
    assign mismatch_w = (gate.y_in !== exp_w);
    assign diff_w     = gate.y_in ^ exp_w;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_idx_d = pass_idx_q;
        settle_d   = settle_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        ffmask_d   = ffmask_q;
        ab_d       = ab_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d      = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                    ffmask_d   = '0;
                    vec_d      = '0;
                    pass_idx_d = '0;
                    ab_d       = 2'b00;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end else begin
                    state_d  = S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch_w) begin
                    if (err_q != CNT_MAX) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d    = 1'b1;
                        ffvec_d  = vec_q;
                        ffmask_d = diff_w;
                    end
                end
                if ((vec_q == 2'd3) && (pass_idx_q == LAST_PASS)) begin
                    ab_d    = 2'b00;
                    state_d = S_DONE;
                end else begin
                    vec_d = vec_q + 2'd1;
                    ab_d  = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        pass_idx_d = pass_idx_q + PASS_W'(1);
                    end
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            pass_idx_q <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            ffmask_q   <= '0;
            ab_q       <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_idx_q <= pass_idx_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
            ffmask_q   <= ffmask_d;
            ab_q       <= ab_d;
        end
    end

    assign gate.a_out       = ab_q[1];
    assign gate.b_out       = ab_q[0];
    assign busy             = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done             = (state_q == S_DONE);
    assign pass             = (state_q == S_DONE) && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_mask  = ffmask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench over three parameter sets with randomized fault masks
`timescale 1ns/1ps
module tb_gate_sweep_checker;

    localparam int NCFG = 3;

    function automatic int cfg_settle(input int i);
        case (i)
            0: return 2;
            1: return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_passes(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int cfg_cntw(input int i);
        return (i == 1) ? 2 : 8;
    endfunction

    typedef struct {
        int         acc;
        int         lat;
        int         err;
        bit         ffv;
        logic [1:0] ffvec;
        logic [7:0] ffmask;
        bit         pass;
        int         nvec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] golden(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {~a, ~b, a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    // Model: a vector mismatches exactly when its injected fault mask is nonzero.
    function automatic exp_t model(input int p, input int s, input int cw, input logic [3:0][7:0] fm);
        exp_t e;
        int   cap;
        cap      = (1 << cw) - 1;
        e.acc    = 0;
        e.lat    = 4 * p * (s + 2);
        e.err    = 0;
        e.ffv    = 1'b0;
        e.ffvec  = 2'b00;
        e.ffmask = 8'h00;
        e.nvec   = 4 * p;
        for (int i = 0; i < p; i++) begin
            for (int v = 0; v < 4; v++) begin
                if (fm[v] != 8'h00) begin
                    if (e.err < cap) e.err++;
                    if (!e.ffv) begin
                        e.ffv    = 1'b1;
                        e.ffvec  = v[1:0];
                        e.ffmask = fm[v];
                    end
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int S  = cfg_settle(g);
        localparam int P  = cfg_passes(g);
        localparam int CW = cfg_cntw(g);
        localparam int L  = 4 * P * (S + 2);

        logic            rst;
        logic            start;
        logic            busy, done, pass, ffv;
        logic [CW-1:0]   err;
        logic [1:0]      ffvec;
        logic [7:0]      ffmask;
        logic [3:0][7:0] fmask;
        logic [31:0]     outs_w;
        bit              fin = 1'b0;
        exp_t            q[$];

        gate_sweep_checker_if gif ();

        assign gif.y_in = golden({gif.a_out, gif.b_out}) ^ fmask[{gif.a_out, gif.b_out}];
        assign outs_w   = 32'({busy, done, pass, ffv, ffvec, ffmask, gif.a_out, gif.b_out, err});

        gate_sweep_checker #(
            .SETTLE_CYCLES (S),
            .NUM_PASSES    (P),
            .CNT_W         (CW)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start),
            .gate             (gif),
            .busy             (busy),
            .done             (done),
            .pass             (pass),
            .err_count        (err),
            .first_fail_valid (ffv),
            .first_fail_vec   (ffvec),
            .first_fail_mask  (ffmask)
        );

        logic [1:0] obs[$];
        bit         prev_busy = 1'b0;
        bit         prev_done = 1'b0;
        logic [1:0] last_ab   = 2'b00;

        always @(negedge clk) begin
            exp_t e;
            bit   ok;
            if (busy) begin
                if (!prev_busy) obs.delete();
                if (!prev_busy || {gif.a_out, gif.b_out} != last_ab) obs.push_back({gif.a_out, gif.b_out});
                last_ab = {gif.a_out, gif.b_out};
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk($sformatf("c%0d.unexpected_done", g), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("c%0d.latency", g), cyc - e.acc, e.lat);
                    chk($sformatf("c%0d.err_count", g), err, e.err);
                    chk($sformatf("c%0d.pass", g), pass, e.pass);
                    chk($sformatf("c%0d.ff_valid", g), ffv, e.ffv);
                    chk($sformatf("c%0d.ff_vec", g), ffvec, e.ffvec);
                    chk($sformatf("c%0d.ff_mask", g), ffmask, e.ffmask);
                    chk($sformatf("c%0d.ab_at_done", g), {gif.a_out, gif.b_out}, 2'b00);
                    ok = (obs.size() == e.nvec);
                    for (int i = 0; i < obs.size(); i++) begin
                        if (obs[i] != 2'(i % 4)) ok = 1'b0;
                    end
                    chk($sformatf("c%0d.vec_seq(n=%0d)", g, obs.size()), ok, 1'b1);
                end
            end
            prev_busy = busy;
            prev_done = done;
        end

        initial begin
            exp_t e;
            int   k, t;
            rst   = 1'b1;
            start = 1'b0;
            fmask = '0;
            repeat (3) @(negedge clk);
            chk($sformatf("c%0d.reset_outputs", g), outs_w, 0);
            rst = 1'b0;
            for (int r = 0; r < 14; r++) begin
                fmask = '0;
                if (r == 1) begin
                    fmask[3] = 8'h20;
                end else if (r == 2) begin
                    for (int v = 0; v < 4; v++) fmask[v] = golden(v[1:0]);
                end else if (r > 2) begin
                    for (int v = 0; v < 4; v++) begin
                        case ($urandom % 4)
                            0, 1:    fmask[v] = 8'h00;
                            2:       fmask[v] = 8'h01 << ($urandom % 8);
                            default: fmask[v] = 8'($urandom);
                        endcase
                    end
                end
                if (r == 3 || r == 9) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    k = (r == 3) ? 2 * (S + 2) + 1 : $urandom_range(1, L - 3);
                    repeat (k) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    chk($sformatf("c%0d.abort_clear", g), outs_w, 0);
                    rst = 1'b0;
                end else if (r == 4) begin
                    rst   = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    chk($sformatf("c%0d.rst_beats_start", g), outs_w, 0);
                    rst   = 1'b0;
                    start = 1'b0;
                end else begin
                    start  = 1'b1;
                    e      = model(P, S, CW, fmask);
                    e.acc  = cyc + 1;
                    q.push_back(e);
                    @(negedge clk);
                    start = 1'b0;
                    if ($urandom % 2 == 1) begin
                        repeat ($urandom_range(0, L - 2)) @(negedge clk);
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                    end
                    t = 0;
                    while (!done && t < L + 20) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!done) chk($sformatf("c%0d.done_timeout", g), 0, 1);
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    chk($sformatf("c%0d.done_hold", g), done, 1'b1);
                end
            end
            repeat (3) @(negedge clk);
            chk($sformatf("c%0d.queue_drained", g), q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

    initial begin
        wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
